// File: rtl/stage_2_issue_scheduler_if.sv
// Issue-scheduler bus: symbol input handshake and issue-slot output handshake.
// The slave modport is the scheduler's view; the master modport is the view of
// whatever drives symbols in and consumes issue slots.
interface stage_2_issue_scheduler_if #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_bool;
    logic [SYMBOL_WIDTH-1:0] in_symbol;
    logic [RANGE_WIDTH-1:0]  in_fl;
    logic [RANGE_WIDTH-1:0]  in_fh;
    logic [SYMBOL_WIDTH-1:0] in_nsyms;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_bool_1;
    logic                    out_bool_2;
    logic [SYMBOL_WIDTH-1:0] out_symbol_1;
    logic [SYMBOL_WIDTH-1:0] out_symbol_2;
    logic [RANGE_WIDTH-1:0]  out_fl;
    logic [RANGE_WIDTH-1:0]  out_fh;
    logic [SYMBOL_WIDTH-1:0] out_nsyms;
    logic                    out_last;
    logic                    frame_done;

    modport master (
        output in_valid, in_bool, in_symbol, in_fl, in_fh, in_nsyms, in_last, out_ready,
        input  in_ready, out_valid, out_bool_1, out_bool_2, out_symbol_1, out_symbol_2,
               out_fl, out_fh, out_nsyms, out_last, frame_done
    );

    modport slave (
        input  in_valid, in_bool, in_symbol, in_fl, in_fh, in_nsyms, in_last, out_ready,
        output in_ready, out_valid, out_bool_1, out_bool_2, out_symbol_1, out_symbol_2,
               out_fl, out_fh, out_nsyms, out_last, frame_done
    );
endinterface

// File: rtl/stage_2_issue_scheduler.sv
// stage_2_issue_scheduler: buffers entropy-coder symbols and packs two
// consecutive boolean symbols of the same frame into one issue slot; CDF
// symbols always issue alone. A lone bool at the head may wait up to
// PAIR_WAIT cycles for a partner.
// Optional feature macro: STAGE2_SCHED_STATS_EN adds saturating slot counters.
module stage_2_issue_scheduler #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PAIR_WAIT    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    stage_2_issue_scheduler_if.slave  bus
`ifdef STAGE2_SCHED_STATS_EN
    ,
    output logic [31:0]               cnt_pair,
    output logic [31:0]               cnt_single_bool,
    output logic [31:0]               cnt_cdf
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (PAIR_WAIT > 1) ? $clog2(PAIR_WAIT) : 1;

    typedef struct packed {
        logic                    is_bool;
        logic                    last;
        logic [SYMBOL_WIDTH-1:0] symbol;
        logic [SYMBOL_WIDTH-1:0] nsyms;
        logic [RANGE_WIDTH-1:0]  fl;
        logic [RANGE_WIDTH-1:0]  fh;
    } entry_t;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    entry_t                  mem_r [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]           count_r, count_next_s;
    logic                    in_ready_r;
    state_t                  state_r, state_next_s;
    logic [WW-1:0]           wait_cnt_r, wait_cnt_next_s;
    entry_t                  head_s, next_s;
    logic                    push_s, load_s, issue_s, pair_s;
    logic [1:0]              pop_cnt_s;
    logic                    out_valid_r, out_bool_1_r, out_bool_2_r, out_last_r, frame_done_r;
    logic [SYMBOL_WIDTH-1:0] out_symbol_1_r, out_symbol_2_r, out_nsyms_r;
    logic [RANGE_WIDTH-1:0]  out_fl_r, out_fh_r;

    assign head_s = mem_r[rd_ptr_r];
    assign next_s = mem_r[rd_ptr_r + AW'(1)];
    assign push_s = bus.in_valid && in_ready_r;
    assign load_s = !out_valid_r || bus.out_ready;

    // Issue decision and pairing FSM next-state: resolve the head entry when the slot register can load.
    always_comb begin
        issue_s         = 1'b0;
        pair_s          = 1'b0;
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        if (!load_s) begin
            state_next_s    = state_r;
            wait_cnt_next_s = wait_cnt_r;
        end else if (count_r == CW'(0)) begin
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = '0;
        end else if (!head_s.is_bool || head_s.last) begin
            issue_s         = 1'b1;
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = '0;
        end else if (count_r >= CW'(2)) begin
            issue_s         = 1'b1;
            pair_s          = next_s.is_bool;
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = '0;
        end else if (PAIR_WAIT == 0) begin
            issue_s         = 1'b1;
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = '0;
        end else if (state_r == ST_WAIT && wait_cnt_r == WW'(PAIR_WAIT - 1)) begin
            // partner never came: give up and issue the bool alone
            issue_s         = 1'b1;
            state_next_s    = ST_IDLE;
            wait_cnt_next_s = '0;
        end else begin
            state_next_s    = ST_WAIT;
            wait_cnt_next_s = (state_r == ST_WAIT) ? wait_cnt_r + WW'(1) : '0;
        end
        pop_cnt_s    = issue_s ? (pair_s ? 2'd2 : 2'd1) : 2'd0;
        count_next_s = count_r + CW'(push_s) - CW'(pop_cnt_s);
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Symbol FIFO storage, pointers, occupancy and registered in_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= '{is_bool: bus.in_bool, last: bus.in_last, symbol: bus.in_symbol,
                                     nsyms: bus.in_nsyms, fl: bus.in_fl, fh: bus.in_fh};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r   <= rd_ptr_r + AW'(pop_cnt_s);
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < CW'(FIFO_DEPTH));
        end
    end

    // Issue slot register: loads when empty or accepted, otherwise holds every field.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r    <= 1'b0;
            out_bool_1_r   <= 1'b0;
            out_bool_2_r   <= 1'b0;
            out_symbol_1_r <= '0;
            out_symbol_2_r <= '0;
            out_fl_r       <= '0;
            out_fh_r       <= '0;
            out_nsyms_r    <= '0;
            out_last_r     <= 1'b0;
        end else if (load_s) begin
            out_valid_r    <= issue_s;
            out_bool_1_r   <= issue_s && head_s.is_bool;
            out_bool_2_r   <= pair_s;
            out_symbol_1_r <= !issue_s ? '0 :
                              (head_s.is_bool ? SYMBOL_WIDTH'(head_s.symbol[0]) : head_s.symbol);
            out_symbol_2_r <= pair_s ? SYMBOL_WIDTH'(next_s.symbol[0]) : '0;
            out_fl_r       <= (issue_s && !head_s.is_bool) ? head_s.fl : '0;
            out_fh_r       <= (issue_s && !head_s.is_bool) ? head_s.fh : '0;
            out_nsyms_r    <= (issue_s && !head_s.is_bool) ? head_s.nsyms : '0;
            out_last_r     <= issue_s && (head_s.last || (pair_s && next_s.last));
        end else begin
            out_valid_r    <= out_valid_r;
        end
    end

    // End-of-frame pulse one cycle after the slot carrying last is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && bus.out_ready && out_last_r;
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_bool_1   = out_bool_1_r;
    assign bus.out_bool_2   = out_bool_2_r;
    assign bus.out_symbol_1 = out_symbol_1_r;
    assign bus.out_symbol_2 = out_symbol_2_r;
    assign bus.out_fl       = out_fl_r;
    assign bus.out_fh       = out_fh_r;
    assign bus.out_nsyms    = out_nsyms_r;
    assign bus.out_last     = out_last_r;
    assign bus.frame_done   = frame_done_r;

`ifdef STAGE2_SCHED_STATS_EN
    logic [31:0] cnt_pair_r, cnt_single_bool_r, cnt_cdf_r;
    logic        accept_s;

    // Counter update: clear at frame end, then add this cycle's accepted slot, saturating.
    function automatic logic [31:0] stat_next(input logic [31:0] cnt, input logic clr, input logic inc);
        logic [31:0] base;
        base = clr ? 32'd0 : cnt;
        return (inc && base != 32'hFFFF_FFFF) ? base + 32'd1 : base;
    endfunction

    assign accept_s = out_valid_r && bus.out_ready;

    // Per-kind slot statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_pair_r        <= 32'd0;
            cnt_single_bool_r <= 32'd0;
            cnt_cdf_r         <= 32'd0;
        end else begin
            cnt_pair_r        <= stat_next(cnt_pair_r, frame_done_r, accept_s && out_bool_2_r);
            cnt_single_bool_r <= stat_next(cnt_single_bool_r, frame_done_r,
                                           accept_s && out_bool_1_r && !out_bool_2_r);
            cnt_cdf_r         <= stat_next(cnt_cdf_r, frame_done_r, accept_s && !out_bool_1_r);
        end
    end

    assign cnt_pair        = cnt_pair_r;
    assign cnt_single_bool = cnt_single_bool_r;
    assign cnt_cdf         = cnt_cdf_r;
`endif
endmodule

// File: tb/tb_stage_2_issue_scheduler.sv
// Directed bench for stage_2_issue_scheduler (PAIR_WAIT=3, FIFO_DEPTH=4).
module tb_stage_2_issue_scheduler;
    localparam int RW     = 16;
    localparam int SW     = 4;
    localparam int SLOT_W = 2 + 3 * SW + 2 * RW + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    stage_2_issue_scheduler_if #(.RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW)) bus ();

`ifdef STAGE2_SCHED_STATS_EN
    logic [31:0] cnt_pair, cnt_single_bool, cnt_cdf;
`endif

    stage_2_issue_scheduler #(
        .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .FIFO_DEPTH(4), .PAIR_WAIT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef STAGE2_SCHED_STATS_EN
        ,
        .cnt_pair(cnt_pair),
        .cnt_single_bool(cnt_single_bool),
        .cnt_cdf(cnt_cdf)
`endif
    );

    function automatic logic [SLOT_W-1:0] mk_slot(input logic b1, input logic b2,
            input logic [SW-1:0] s1, input logic [SW-1:0] s2, input logic [RW-1:0] fl,
            input logic [RW-1:0] fh, input logic [SW-1:0] ns, input logic last);
        return {b1, b2, s1, s2, fl, fh, ns, last};
    endfunction

    function automatic logic [SLOT_W-1:0] cur_slot();
        return {bus.out_bool_1, bus.out_bool_2, bus.out_symbol_1, bus.out_symbol_2,
                bus.out_fl, bus.out_fh, bus.out_nsyms, bus.out_last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic [SW-1:0] s, input logic [RW-1:0] fl,
                        input logic [RW-1:0] fh, input logic [SW-1:0] ns, input logic last);
        logic ok;
        logic done;
        done = 1'b0;
        bus.in_valid = 1'b1; bus.in_bool = b; bus.in_symbol = s;
        bus.in_fl = fl; bus.in_fh = fh; bus.in_nsyms = ns; bus.in_last = last;
        for (int i = 0; i < 20 && !done; i++) begin
            ok = bus.in_ready;
            step();
            if (ok) done = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL send_timeout: symbol %0d never accepted within 20 cycles", s);
        end
    endtask

    // waits for a valid slot, compares it, then lets it be accepted (out_ready=1)
    task automatic expect_slot(input string name, input logic [SLOT_W-1:0] exp, output int lat);
        logic found;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.out_valid) found = 1'b1;
            else begin step(); lat++; end
        end
        n_vec++;
        if (!found) begin
            n_miss++;
            $display("FAIL %s: no slot within 20 cycles, out_valid=%b required 1", name, bus.out_valid);
        end else begin
            if (cur_slot() !== exp) begin
                n_miss++;
                $display("FAIL %s: slot got %h required %h", name, cur_slot(), exp);
            end
            step();
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_bool = 1'b0; bus.in_symbol = '0; bus.in_fl = '0;
        bus.in_fh = '0; bus.in_nsyms = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({bus.out_valid, cur_slot(), bus.frame_done} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: got valid=%b slot=%h done=%b required all 0",
                     bus.out_valid, cur_slot(), bus.frame_done);
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_miss++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_pair_back_to_back();
        int lat;
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b0);
        send(1'b1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0);
        expect_slot("pair_b2b", mk_slot(1'b1, 1'b1, 4'd1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0), lat);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_miss++; $display("FAIL pair_b2b_single_slot: out_valid got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_cdf_then_bool();
        int lat;
        send(1'b0, 4'd2, 16'h4000, 16'h2000, 4'd4, 1'b0);
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b0);
        expect_slot("cdf_slot", mk_slot(1'b0, 1'b0, 4'd2, 4'd0, 16'h4000, 16'h2000, 4'd4, 1'b0), lat);
        expect_slot("bool_after_cdf", mk_slot(1'b1, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0), lat);
    endtask

    task automatic test_min_latency();
        int lat;
        send(1'b0, 4'd5, 16'h1234, 16'h0100, 4'd9, 1'b1);
        expect_slot("cdf_last", mk_slot(1'b0, 1'b0, 4'd5, 4'd0, 16'h1234, 16'h0100, 4'd9, 1'b1), lat);
        n_vec++;
        if (lat !== 1) begin
            n_miss++; $display("FAIL min_latency: got %0d cycles required 1", lat);
        end
        n_vec++;
        if (bus.frame_done !== 1'b1) begin
            n_miss++; $display("FAIL cdf_frame_done: got %b required 1", bus.frame_done);
        end
        step();
        n_vec++;
        if (bus.frame_done !== 1'b0) begin
            n_miss++; $display("FAIL frame_done_pulse_width: got %b required 0", bus.frame_done);
        end
    endtask

    task automatic test_lone_wait();
        int lat;
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b0);
        expect_slot("lone_bool", mk_slot(1'b1, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0), lat);
        n_vec++;
        if (lat !== 4) begin
            n_miss++; $display("FAIL lone_wait_latency: got %0d cycles required 4", lat);
        end
    endtask

    task automatic test_late_partner();
        int lat;
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b0);
        step();
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b1);
        expect_slot("late_pair", mk_slot(1'b1, 1'b1, 4'd1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b1), lat);
        n_vec++;
        if (bus.frame_done !== 1'b1) begin
            n_miss++; $display("FAIL late_pair_frame_done: got %b required 1", bus.frame_done);
        end
    endtask

    task automatic test_frame_boundary();
        int lat;
        send(1'b1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b1);
        send(1'b1, 4'd1, 16'h0, 16'h0, 4'd0, 1'b0);
        expect_slot("frame_end_bool", mk_slot(1'b1, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b1), lat);
        n_vec++;
        if (bus.frame_done !== 1'b1) begin
            n_miss++; $display("FAIL boundary_frame_done: got %b required 1", bus.frame_done);
        end
        expect_slot("next_frame_bool", mk_slot(1'b1, 1'b0, 4'd1, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0), lat);
    endtask

    task automatic test_backpressure();
        int   idx;
        int   lat;
        logic ok;
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (idx < 6); bus.in_bool = 1'b0; bus.in_symbol = SW'(idx + 1);
            bus.in_fl = RW'((idx + 1) * 256); bus.in_fh = RW'(idx + 1); bus.in_nsyms = SW'(idx + 8);
            bus.in_last = 1'b0;
            ok = bus.in_ready;
            step();
            if (ok && idx < 6) idx++;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (idx !== 5) begin
            n_miss++; $display("FAIL bp_accepted: got %0d symbols required 5", idx);
        end
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.out_symbol_1} !== {1'b0, 1'b1, 4'd1}) begin
            n_miss++;
            $display("FAIL bp_stall_state: in_ready=%b out_valid=%b sym=%0d required 0 1 1",
                     bus.in_ready, bus.out_valid, bus.out_symbol_1);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_slot($sformatf("bp_order_%0d", k),
                        mk_slot(1'b0, 1'b0, SW'(k), 4'd0, RW'(k * 256), RW'(k), SW'(k + 7), 1'b0), lat);
        end
        n_vec++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_miss++; $display("FAIL bp_drain: in_ready/out_valid got %b required 10",
                               {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(1'b0, SW'(k), 16'h00FF, 16'h0001, 4'd3, 1'b0);
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_miss++; $display("FAIL rst_mid_setup: out_valid got %b required 1", bus.out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, cur_slot()} !== '0) begin
            n_miss++; $display("FAIL rst_mid_async: valid=%b slot=%h required 0",
                               bus.out_valid, cur_slot());
        end
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_miss++; $display("FAIL rst_mid_stale: stale slot seen got %b required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_pair_back_to_back();
        test_cdf_then_bool();
        test_min_latency();
        test_lone_wait();
        test_late_partner();
        test_frame_boundary();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
